aes_dec_scheduler: RTL and testbench

// - Shares one decryption_top core between NUM_REQ requesters. Jobs are one

---
 rtl/aes_dec_scheduler_if.sv | 36 +++
 rtl/aes_dec_scheduler.sv | 179 +++++++++++++++++
 tb/tb_aes_dec_scheduler.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_scheduler_if.sv
// aes_dec_scheduler_if: requester, core and response signals of the AES
// decryption scheduler bundled into one interface.
// slave  : used by the scheduler itself.
// master : used by the environment (requesters, core, response consumer).
interface aes_dec_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_ciphertext;
  logic [NUM_REQ*128-1:0] req_key;
  logic                   core_start;
  logic [127:0]           core_ciphertext;
  logic [127:0]           core_key;
  logic                   core_done;
  logic [127:0]           core_plaintext;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [127:0]           rsp_plaintext;
  logic                   rsp_error;
  logic                   busy;

  modport slave (
    input  req_valid, req_ciphertext, req_key, core_done, core_plaintext, rsp_ready,
    output req_ready, core_start, core_ciphertext, core_key,
           rsp_valid, rsp_id, rsp_plaintext, rsp_error, busy
  );

  modport master (
    output req_valid, req_ciphertext, req_key, core_done, core_plaintext, rsp_ready,
    input  req_ready, core_start, core_ciphertext, core_key,
           rsp_valid, rsp_id, rsp_plaintext, rsp_error, busy
  );
endinterface

// File: rtl/aes_dec_scheduler.sv
// aes_dec_scheduler: shares one AES decryption core between NUM_REQ
// requesters. Round-robin grant, one job in flight, result returned with the
// requester id over a valid/ready channel.
// Optional feature: define SCHED_TIMEOUT_EN to build the WAIT watchdog that
// turns a missing core_done into an error response.
module aes_dec_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 1,
  parameter int DONE_MASK   = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                clk,
  input logic                reset,
  aes_dec_scheduler_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_t;

  // One spare bit so the saturation limit always fits, even for DONE_MASK=0.
  localparam int              MASK_W   = $clog2(DONE_MASK + 1) + 1;
  localparam logic [MASK_W-1:0] MASK_LIM = MASK_W'(DONE_MASK);
  localparam logic [ID_W-1:0] LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t              state_q;
  logic [ID_W-1:0]     rr_q;
  logic [ID_W-1:0]     rr_d;
  logic [ID_W-1:0]     id_q;
  logic [127:0]        ct_q;
  logic [127:0]        key_q;
  logic [127:0]        pt_q;
  logic                start_q;
  logic                busy_q;
  logic                rsp_valid_q;
  logic [MASK_W-1:0]   mask_q;

  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  req_ready_c;
  logic [127:0]        sel_ct;
  logic [127:0]        sel_key;
  logic                done_ok;

`ifdef SCHED_TIMEOUT_EN
  // Watchdog counts WAIT cycles; WAIT starts one cycle after core_start, so
  // expiring at TIMEOUT_CYC-2 puts rsp_valid exactly TIMEOUT_CYC after start.
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 2);
  logic [WD_W-1:0] wd_q;
  logic            err_q;
  logic            wd_expired;
  assign wd_expired = (wd_q == WD_LAST);
`endif

  // Round-robin search: first valid index at or above the pointer, else wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && bus.req_valid[j] && (ID_W'(j) >= rr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!grant_found && bus.req_valid[j] && (ID_W'(j) < rr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  // One-hot accept in IDLE only, plus the winner's ciphertext/key selection.
  always_comb begin
    req_ready_c = '0;
    sel_ct      = '0;
    sel_key     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if ((state_q == ST_IDLE) && !reset && grant_found && (grant_idx == ID_W'(j))) begin
        req_ready_c[j] = 1'b1;
        sel_ct         = bus.req_ciphertext[j*128 +: 128];
        sel_key        = bus.req_key[j*128 +: 128];
      end
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    rr_d = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
  end

  // A done level left over from the previous job is ignored until the mask runs out.
  assign done_ok = bus.core_done && (mask_q >= MASK_LIM);

  // Job sequencer: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      ct_q        <= '0;
      key_q       <= '0;
      pt_q        <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      mask_q      <= '0;
`ifdef SCHED_TIMEOUT_EN
      wd_q        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (|req_ready_c) begin
            ct_q    <= sel_ct;
            key_q   <= sel_key;
            id_q    <= grant_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          mask_q  <= '0;
`ifdef SCHED_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mask_q != MASK_LIM) mask_q <= mask_q + 1'b1;
          if (done_ok) begin
            pt_q        <= bus.core_plaintext;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
`ifdef SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
          end else if (wd_expired) begin
            pt_q        <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            wd_q <= wd_q + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_q        <= rr_d;
`ifdef SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready       = req_ready_c;
  assign bus.core_start      = start_q;
  assign bus.core_ciphertext = ct_q;
  assign bus.core_key        = key_q;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_id          = id_q;
  assign bus.rsp_plaintext   = pt_q;
  assign bus.busy            = busy_q;
`ifdef SCHED_TIMEOUT_EN
  assign bus.rsp_error       = err_q;
`else
  assign bus.rsp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// tb_aes_dec_scheduler: directed bench for the AES decryption scheduler with a
// behavioural core stub (known-answer vector, configurable latency, stuck or
// absent done).
module tb_aes_dec_scheduler;
  localparam int NUM_REQ     = 2;
  localparam int ID_W        = 1;
  localparam int DONE_MASK   = 2;
  localparam int TIMEOUT_CYC = 64;

  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_A = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] K_A  = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
  localparam logic [127:0] CT_B = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] K_B  = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  localparam logic [127:0] CT_C = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
  localparam logic [127:0] K_C  = 128'h00000000_ffffffff_00000000_ffffffff;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  aes_dec_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  aes_dec_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .DONE_MASK(DONE_MASK), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Core stub: answers the known-answer vector, otherwise ct ^ rotated key.
  function automatic logic [127:0] core_model(input logic [127:0] ct, input logic [127:0] key);
    if (ct == AES_CT && key == AES_KEY) return AES_PT;
    return ct ^ {key[63:0], key[127:64]};
  endfunction

  int           stub_lat  = 3;
  int           stub_mode = 0;   // 0 normal, 1 done stuck high, 2 done never
  int           lat_cnt;
  logic         done_r;
  logic [127:0] pt_r;

  always @(posedge clk) begin
    if (reset) begin
      done_r  <= 1'b0;
      lat_cnt <= 0;
      pt_r    <= '0;
    end else if (bus.core_start) begin
      done_r  <= 1'b0;
      lat_cnt <= stub_lat;
      pt_r    <= core_model(bus.core_ciphertext, bus.core_key);
    end else if (lat_cnt > 0) begin
      lat_cnt <= lat_cnt - 1;
      if (lat_cnt == 1) done_r <= 1'b1;
    end
  end

  assign bus.core_done      = (stub_mode == 1) ? 1'b1 : (stub_mode == 2) ? 1'b0 : done_r;
  assign bus.core_plaintext = pt_r;

  // Event monitor sampled on the falling edge.
  int           starts = 0;
  int           rdy_cycles = 0;
  int           rdy_b2b = 0;
  logic         prev_rdy = 1'b0;
  int           grants[$];
  int           rsp_ids[$];
  logic [127:0] rsp_pts[$];

  always @(negedge clk) begin
    if (bus.core_start === 1'b1) starts <= starts + 1;
    if (bus.req_ready != '0) begin
      rdy_cycles <= rdy_cycles + 1;
      if (prev_rdy) rdy_b2b <= rdy_b2b + 1;
      for (int j = 0; j < NUM_REQ; j++)
        if (bus.req_ready[j] && bus.req_valid[j]) grants.push_back(j);
    end
    prev_rdy <= (bus.req_ready != '0);
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      rsp_ids.push_back(int'(bus.rsp_id));
      rsp_pts.push_back(bus.rsp_plaintext);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rsp(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (bus.rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    bus.req_valid = 2'b01;
    #1;
    vectors++;
    if ({bus.core_start, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_id} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl got start/busy/valid/err/id=%b%b%b%b%b exp 00000",
               bus.core_start, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_id);
    end
    vectors++;
    if (bus.req_ready !== 2'b00) begin
      miscompares++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready);
    end
    vectors++;
    if ({bus.core_ciphertext, bus.core_key, bus.rsp_plaintext} !== '0) begin
      miscompares++; $display("FAIL reset_data got ct=%h key=%h pt=%h exp 0",
                              bus.core_ciphertext, bus.core_key, bus.rsp_plaintext);
    end
    bus.req_valid = 2'b00;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_aes_vector();
    bit ok;
    bus.req_ciphertext[127:0] = AES_CT;
    bus.req_key[127:0]        = AES_KEY;
    bus.req_valid             = 2'b01;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++; $display("FAIL aes_req_ready got %b exp 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    #1;
    vectors++;
    if ({bus.core_start, bus.busy} !== 2'b11) begin
      miscompares++; $display("FAIL aes_launch got start/busy=%b%b exp 11", bus.core_start, bus.busy);
    end
    vectors++;
    if (bus.core_ciphertext !== AES_CT || bus.core_key !== AES_KEY) begin
      miscompares++; $display("FAIL aes_core_inputs got ct=%h key=%h exp ct=%h key=%h",
                              bus.core_ciphertext, bus.core_key, AES_CT, AES_KEY);
    end
    wait_rsp(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL aes_rsp_timeout got no rsp_valid exp rsp_valid within 200 cycles");
    end
    vectors++;
    if (bus.rsp_id !== 1'b0 || bus.rsp_error !== 1'b0) begin
      miscompares++; $display("FAIL aes_rsp_id got id=%0d err=%b exp id=0 err=0", bus.rsp_id, bus.rsp_error);
    end
    vectors++;
    if (bus.rsp_plaintext !== AES_PT) begin
      miscompares++; $display("FAIL aes_plaintext got %h exp %h", bus.rsp_plaintext, AES_PT);
    end
    ack_rsp();
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      miscompares++; $display("FAIL aes_after_ack got valid/busy=%b%b exp 00", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int exp_g[4] = '{0, 1, 0, 1};
    int s0, r0, b0;
    logic [127:0] exp_pt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    grants.delete();
    rsp_ids.delete();
    rsp_pts.delete();
    s0 = starts; r0 = rdy_cycles; b0 = rdy_b2b;
    bus.req_ciphertext = {CT_B, CT_A};
    bus.req_key        = {K_B, K_A};
    bus.rsp_ready      = 1'b1;
    bus.req_valid      = 2'b11;
    for (int n = 0; n < 300 && rsp_ids.size() < 4; n++) tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    tick();
    vectors++;
    if (rsp_ids.size() != 4 || grants.size() != 4) begin
      miscompares++; $display("FAIL rr_counts got rsp=%0d grants=%0d exp 4/4", rsp_ids.size(), grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_pt = (exp_g[i] == 0) ? core_model(CT_A, K_A) : core_model(CT_B, K_B);
        vectors++;
        if (grants[i] != exp_g[i] || rsp_ids[i] != exp_g[i]) begin
          miscompares++; $display("FAIL rr_order[%0d] got grant=%0d id=%0d exp %0d",
                                  i, grants[i], rsp_ids[i], exp_g[i]);
        end
        vectors++;
        if (rsp_pts[i] !== exp_pt) begin
          miscompares++; $display("FAIL rr_plaintext[%0d] got %h exp %h", i, rsp_pts[i], exp_pt);
        end
      end
    end
    vectors++;
    if (starts - s0 != 4) begin
      miscompares++; $display("FAIL rr_core_starts got %0d exp 4", starts - s0);
    end
    vectors++;
    if (rdy_cycles - r0 != 4 || rdy_b2b - b0 != 0) begin
      miscompares++; $display("FAIL rr_ready_pulses got cycles=%0d adjacent=%0d exp 4/0",
                              rdy_cycles - r0, rdy_b2b - b0);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int s1;
    logic [127:0] exp_pt;
    exp_pt = core_model(CT_C, K_C);
    bus.req_ciphertext = {CT_C, CT_A};
    bus.req_key        = {K_C, K_A};
    bus.req_valid      = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(200, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL bp_rsp_timeout got no rsp_valid exp rsp_valid within 200 cycles");
    end
    s1 = starts;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      #1;
      vectors++;
      if ({bus.rsp_valid, bus.rsp_id} !== 2'b11) begin
        miscompares++; $display("FAIL bp_hold[%0d] got valid/id=%b%b exp 11", i, bus.rsp_valid, bus.rsp_id);
      end
      vectors++;
      if (bus.rsp_plaintext !== exp_pt) begin
        miscompares++; $display("FAIL bp_data[%0d] got %h exp %h", i, bus.rsp_plaintext, exp_pt);
      end
      vectors++;
      if (bus.req_ready !== 2'b00) begin
        miscompares++; $display("FAIL bp_req_ready[%0d] got %b exp 00", i, bus.req_ready);
      end
      tick();
    end
    vectors++;
    if (starts != s1) begin
      miscompares++; $display("FAIL bp_core_start got %0d extra exp 0", starts - s1);
    end
    ack_rsp();
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.req_ready} !== 3'b001) begin
      miscompares++; $display("FAIL bp_next_grant got valid=%b ready=%b exp 0/01", bus.rsp_valid, bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(200, ok);
    vectors++;
    if (!ok || bus.rsp_id !== 1'b0) begin
      miscompares++; $display("FAIL bp_second_job got ok=%b id=%0d exp ok=1 id=0", ok, bus.rsp_id);
    end
    ack_rsp();
  endtask

  task automatic test_done_mask();
    logic [127:0] exp_pt;
    exp_pt = core_model(CT_A, K_A);
    stub_mode = 1;
    bus.req_ciphertext = {CT_C, CT_A};
    bus.req_key        = {K_C, K_A};
    bus.req_valid      = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    #1;
    vectors++;
    if (bus.core_start !== 1'b1) begin
      miscompares++; $display("FAIL mask_launch got core_start=%b exp 1", bus.core_start);
    end
    for (int i = 0; i < DONE_MASK + 1; i++) begin
      tick();
      vectors++;
      if (bus.rsp_valid !== 1'b0) begin
        miscompares++; $display("FAIL mask_early[%0d] got rsp_valid=%b exp 0", i, bus.rsp_valid);
      end
    end
    tick();
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_plaintext !== exp_pt) begin
      miscompares++; $display("FAIL mask_accept got valid=%b pt=%h exp 1 %h", bus.rsp_valid, bus.rsp_plaintext, exp_pt);
    end
    stub_mode = 0;
    ack_rsp();
  endtask

  task automatic test_reset_mid();
    int seen;
    bit ok;
    stub_lat = 20;
    bus.req_ciphertext = {CT_B, CT_A};
    bus.req_key        = {K_B, K_A};
    bus.req_valid      = 2'b10;
    tick();
    bus.req_valid = 2'b00;
    tick(); tick(); tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL rmid_busy got %b exp 1", bus.busy);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({bus.core_start, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_id, bus.req_ready} !== '0) begin
      miscompares++; $display("FAIL rmid_ctrl got start/busy/valid/err/id/ready=%b%b%b%b%b%b exp 0",
                              bus.core_start, bus.busy, bus.rsp_valid, bus.rsp_error, bus.rsp_id, bus.req_ready);
    end
    vectors++;
    if ({bus.core_ciphertext, bus.core_key, bus.rsp_plaintext} !== '0) begin
      miscompares++; $display("FAIL rmid_data got ct=%h key=%h pt=%h exp 0",
                              bus.core_ciphertext, bus.core_key, bus.rsp_plaintext);
    end
    reset = 1'b0;
    stub_lat = 3;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++; $display("FAIL rmid_no_rsp got %0d rsp_valid cycles exp 0", seen);
    end
    bus.req_valid = 2'b11;
    #1;
    vectors++;
    if (bus.req_ready !== 2'b01) begin
      miscompares++; $display("FAIL rmid_rr_ptr got req_ready=%b exp 01", bus.req_ready);
    end
    tick();
    bus.req_valid = 2'b00;
    wait_rsp(200, ok);
    vectors++;
    if (!ok || bus.rsp_id !== 1'b0) begin
      miscompares++; $display("FAIL rmid_fresh_job got ok=%b id=%0d exp ok=1 id=0", ok, bus.rsp_id);
    end
    ack_rsp();
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    stub_mode = 2;
    bus.req_ciphertext = {CT_B, CT_A};
    bus.req_key        = {K_B, K_A};
    bus.req_valid      = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < TIMEOUT_CYC + 50) begin
      tick();
      n++;
    end
    vectors++;
    if (n != TIMEOUT_CYC) begin
      miscompares++; $display("FAIL to_latency got %0d cycles exp %0d", n, TIMEOUT_CYC);
    end
    vectors++;
    if (bus.rsp_error !== 1'b1 || bus.rsp_plaintext !== '0) begin
      miscompares++; $display("FAIL to_error got err=%b pt=%h exp err=1 pt=0", bus.rsp_error, bus.rsp_plaintext);
    end
    stub_mode = 0;
    ack_rsp();
    #1;
    vectors++;
    if ({bus.rsp_valid, bus.rsp_error, bus.busy} !== 3'b000) begin
      miscompares++; $display("FAIL to_clear got valid/err/busy=%b%b%b exp 000",
                              bus.rsp_valid, bus.rsp_error, bus.busy);
    end
  endtask
`else
  task automatic test_wait_forever();
    int seen;
    stub_mode = 2;
    bus.req_ciphertext = {CT_B, CT_A};
    bus.req_key        = {K_B, K_A};
    bus.req_valid      = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    seen = 0;
    for (int i = 0; i < TIMEOUT_CYC + 40; i++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0 || bus.busy !== 1'b1 || bus.rsp_error !== 1'b0) begin
      miscompares++; $display("FAIL wait_forever got rsp_cycles=%0d busy=%b err=%b exp 0/1/0",
                              seen, bus.busy, bus.rsp_error);
    end
    stub_mode = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    reset              = 1'b1;
    bus.req_valid      = '0;
    bus.req_ciphertext = '0;
    bus.req_key        = '0;
    bus.rsp_ready      = 1'b0;
    tick(); tick(); tick();
    test_reset();
    test_aes_vector();
    test_back_to_back();
    test_backpressure();
    test_done_mask();
    test_reset_mid();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_wait_forever();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
